// File: rtl/fir_wb_sequencer.sv
// Wishbone-programmed sequencer that streams LEN words from SRC through the FIR window into DST.
// Optional ack/poll watchdog is compiled in with `define FIR_SEQ_TIMEOUT_EN.
module fir_wb_sequencer #(
    parameter logic [31:0] FIR_BASE    = 32'h3000_0000,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        s_cyc_i,
    input  logic        s_stb_i,
    input  logic        s_we_i,
    input  logic [3:0]  s_adr_i,
    input  logic [31:0] s_dat_i,
    output logic [31:0] s_dat_o,
    output logic        s_ack_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    input  logic        m_ack_i
);
    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        SETLEN = 4'd1,
        START  = 4'd2,
        RDX    = 4'd3,
        WRX    = 4'd4,
        RDY    = 4'd5,
        WRY    = 4'd6,
        POLL   = 4'd7,
        FIN    = 4'd8
    } state_t;

    localparam logic [31:0] OFS_CTRL = 32'h0000_0000;
    localparam logic [31:0] OFS_LEN  = 32'h0000_0010;
    localparam logic [31:0] OFS_X    = 32'h0000_0080;
    localparam logic [31:0] OFS_Y    = 32'h0000_0084;

    state_t      state_r, state_s;
    logic [31:0] src_r, src_s, dst_r, dst_s, data_r, data_s;
    logic [9:0]  len_r, len_s, idx_r, idx_s;
    logic        done_r, done_s, err_r, err_s;
    logic        busy_s, s_access_s, go_s;
    logic [31:0] s_rdata_s, s_dat_s;
    logic        req_valid_s, req_we_s;
    logic [31:0] req_adr_s, req_dat_s, word_ofs_s;
    logic        cyc_s, we_s;
    logic [31:0] adr_s, mdat_s;
`ifdef FIR_SEQ_TIMEOUT_EN
    logic [31:0] wait_cnt_r, wait_cnt_s, poll_cnt_r, poll_cnt_s;
`endif

    // Configuration slave: zero-wait-state ack, register writes only while idle, read mux.
    always_comb begin
        busy_s     = (state_r != IDLE);
        s_access_s = s_cyc_i & s_stb_i & ~s_ack_o;
        go_s       = s_access_s & s_we_i & ~busy_s & (s_adr_i == 4'h0) & s_dat_i[0];
        src_s      = src_r;
        dst_s      = dst_r;
        len_s      = len_r;
        if (s_access_s && s_we_i && !busy_s) begin
            case (s_adr_i)
                4'h4:    src_s = s_dat_i;
                4'h8:    dst_s = s_dat_i;
                4'hC:    len_s = s_dat_i[9:0];
                default: len_s = len_r;
            endcase
        end else begin
            len_s = len_r;
        end
        case (s_adr_i)
            4'h0:    s_rdata_s = {28'd0, err_r, done_r, busy_s, 1'b0};
            4'h4:    s_rdata_s = src_r;
            4'h8:    s_rdata_s = dst_r;
            4'hC:    s_rdata_s = {22'd0, len_r};
            default: s_rdata_s = 32'd0;
        endcase
        if (s_access_s && !s_we_i) begin
            s_dat_s = s_rdata_s;
        end else begin
            s_dat_s = 32'd0;
        end
    end

    // Master request presented by each transaction state.
    always_comb begin
        word_ofs_s  = {20'd0, idx_r, 2'b00};
        req_valid_s = 1'b1;
        req_we_s    = 1'b0;
        req_adr_s   = 32'd0;
        req_dat_s   = 32'd0;
        case (state_r)
            SETLEN: begin req_we_s = 1'b1; req_adr_s = FIR_BASE + OFS_LEN;  req_dat_s = {22'd0, len_r}; end
            START:  begin req_we_s = 1'b1; req_adr_s = FIR_BASE + OFS_CTRL; req_dat_s = 32'd1;          end
            RDX:    begin req_adr_s = src_r + word_ofs_s;                                               end
            WRX:    begin req_we_s = 1'b1; req_adr_s = FIR_BASE + OFS_X;    req_dat_s = data_r;         end
            RDY:    begin req_adr_s = FIR_BASE + OFS_Y;                                                 end
            WRY:    begin req_we_s = 1'b1; req_adr_s = dst_r + word_ofs_s;  req_dat_s = data_r;         end
            POLL:   begin req_adr_s = FIR_BASE + OFS_CTRL;                                              end
            default: req_valid_s = 1'b0;
        endcase
    end

    // Sequencer next state: issue when the bus is idle, hold until ack, advance on the ack cycle.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        data_s  = data_r;
        done_s  = done_r;
        err_s   = err_r;
        cyc_s   = m_cyc_o;
        we_s    = m_we_o;
        adr_s   = m_adr_o;
        mdat_s  = m_dat_o;
`ifdef FIR_SEQ_TIMEOUT_EN
        wait_cnt_s = 32'd0;
        poll_cnt_s = poll_cnt_r;
`endif
        case (state_r)
            IDLE: begin
                if (go_s) begin
                    done_s  = 1'b0;
                    err_s   = 1'b0;
                    idx_s   = 10'd0;
`ifdef FIR_SEQ_TIMEOUT_EN
                    poll_cnt_s = 32'd0;
`endif
                    state_s = (len_r == 10'd0) ? FIN : SETLEN;
                end else begin
                    state_s = IDLE;
                end
            end
            FIN: begin
                done_s  = 1'b1;
                state_s = IDLE;
            end
            default: begin
                if (!req_valid_s) begin
                    cyc_s   = 1'b0;
                    state_s = IDLE;
                end else if (!m_cyc_o) begin
                    cyc_s  = 1'b1;
                    we_s   = req_we_s;
                    adr_s  = req_adr_s;
                    mdat_s = req_dat_s;
                end else if (m_ack_i) begin
                    cyc_s = 1'b0;
                    case (state_r)
                        SETLEN: state_s = START;
                        START:  state_s = RDX;
                        RDX:    begin data_s = m_dat_i; state_s = WRX; end
                        WRX:    state_s = RDY;
                        RDY:    begin data_s = m_dat_i; state_s = WRY; end
                        WRY: begin
                            // idx+1 compared at 11 bits so LEN=1023 cannot wrap the test.
                            if (({1'b0, idx_r} + 11'd1) < {1'b0, len_r}) begin
                                idx_s   = idx_r + 10'd1;
                                state_s = RDX;
                            end else begin
                                state_s = POLL;
                            end
                        end
                        POLL: begin
                            if (m_dat_i[1]) begin
                                state_s = FIN;
                            end else begin
                                state_s = POLL;
`ifdef FIR_SEQ_TIMEOUT_EN
                                if ((poll_cnt_r + 32'd1) >= 32'(TIMEOUT_CYC)) begin
                                    done_s     = 1'b1;
                                    err_s      = 1'b1;
                                    poll_cnt_s = 32'd0;
                                    state_s    = IDLE;
                                end else begin
                                    poll_cnt_s = poll_cnt_r + 32'd1;
                                end
`endif
                            end
                        end
                        default: state_s = IDLE;
                    endcase
                end else begin
`ifdef FIR_SEQ_TIMEOUT_EN
                    if (wait_cnt_r >= (32'(TIMEOUT_CYC) - 32'd1)) begin
                        cyc_s   = 1'b0;
                        done_s  = 1'b1;
                        err_s   = 1'b1;
                        state_s = IDLE;
                    end else begin
                        wait_cnt_s = wait_cnt_r + 32'd1;
                    end
`else
                    cyc_s = 1'b1;
`endif
                end
            end
        endcase
    end

    // State, configuration and bus output registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r <= IDLE;
            src_r   <= 32'd0;
            dst_r   <= 32'd0;
            len_r   <= 10'd0;
            idx_r   <= 10'd0;
            data_r  <= 32'd0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            s_ack_o <= 1'b0;
            s_dat_o <= 32'd0;
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
            m_we_o  <= 1'b0;
            m_adr_o <= 32'd0;
            m_dat_o <= 32'd0;
`ifdef FIR_SEQ_TIMEOUT_EN
            wait_cnt_r <= 32'd0;
            poll_cnt_r <= 32'd0;
`endif
        end else begin
            state_r <= state_s;
            src_r   <= src_s;
            dst_r   <= dst_s;
            len_r   <= len_s;
            idx_r   <= idx_s;
            data_r  <= data_s;
            done_r  <= done_s;
            err_r   <= err_s;
            s_ack_o <= s_access_s;
            s_dat_o <= s_dat_s;
            m_cyc_o <= cyc_s;
            m_stb_o <= cyc_s;
            m_we_o  <= we_s;
            m_adr_o <= adr_s;
            m_dat_o <= mdat_s;
`ifdef FIR_SEQ_TIMEOUT_EN
            wait_cnt_r <= wait_cnt_s;
            poll_cnt_r <= poll_cnt_s;
`endif
        end
    end

endmodule

// File: tb/tb_fir_wb_sequencer.sv
// Directed bench for fir_wb_sequencer: a bus responder models memory and the FIR core,
// and expected master transactions are queued at GO and compared as the DUT completes them.
module tb_fir_wb_sequencer;
    localparam logic [31:0] FB  = 32'h3000_0000;
    localparam int          LAT = 1;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        s_cyc_i, s_stb_i, s_we_i;
    logic [3:0]  s_adr_i;
    logic [31:0] s_dat_i, s_dat_o;
    logic        s_ack_o;
    logic        m_cyc_o, m_stb_o, m_we_o;
    logic [31:0] m_adr_o, m_dat_o, m_dat_i;
    logic        m_ack_i;

    fir_wb_sequencer dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_we_i(s_we_i), .s_adr_i(s_adr_i),
        .s_dat_i(s_dat_i), .s_dat_o(s_dat_o), .s_ack_o(s_ack_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_adr_o(m_adr_o),
        .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int          total = 0;
    int          bad   = 0;
    int          cyc_cycles;
    logic [64:0] exp_q[$];
    logic [64:0] obs_q[$];
    logic [31:0] stall_adr;

    function automatic logic [31:0] xval(input logic [31:0] a);
        return a * 32'd7 + 32'h0000_0011;
    endfunction

    function automatic logic [31:0] firf(input logic [31:0] x);
        return x * 32'd3 + 32'h0000_1234;
    endfunction

    function automatic logic [64:0] txn(input logic we, input logic [31:0] a, input logic [31:0] d);
        return {we, a, (we ? d : 32'd0)};
    endfunction

    task automatic chk(input string tag, input logic [64:0] o, input logic [64:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Master-side slave: memory returns xval(adr), FIR returns firf(last X), ap_done on 3rd poll.
    initial begin : responder
        int          lat;
        int          polls;
        logic [31:0] fir_x;
        lat = 0; polls = 0; fir_x = 32'd0; cyc_cycles = 0;
        m_ack_i = 1'b0; m_dat_i = 32'd0;
        forever begin
            @(negedge wb_clk_i);
            if (wb_rst_i || m_ack_i) begin
                m_ack_i = 1'b0; m_dat_i = 32'd0; lat = 0;
            end else if (m_cyc_o && m_stb_o) begin
                cyc_cycles++;
                if (m_adr_o == stall_adr) begin
                    lat = 0;
                end else if (lat < LAT) begin
                    lat++;
                end else begin
                    lat = 0;
                    m_ack_i = 1'b1;
                    obs_q.push_back(txn(m_we_o, m_adr_o, m_dat_o));
                    if (m_we_o) begin
                        if (m_adr_o == FB) polls = 0;
                        else if (m_adr_o == FB + 32'h80) fir_x = m_dat_o;
                    end else if (m_adr_o == FB + 32'h84) begin
                        m_dat_i = firf(fir_x);
                    end else if (m_adr_o == FB) begin
                        polls++;
                        m_dat_i = (polls >= 3) ? 32'h2 : 32'h0;
                    end else begin
                        m_dat_i = xval(m_adr_o);
                    end
                end
            end else begin
                lat = 0;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
        logic got;
        got = 1'b0;
        @(negedge wb_clk_i);
        s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b1; s_adr_i = a; s_dat_i = d;
        for (int k = 0; k < 4 && !got; k++) begin
            @(negedge wb_clk_i);
            got = s_ack_o;
        end
        s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
        chk("s_ack_wr", 65'(got), 65'd1);
    endtask

    task automatic wb_read(input logic [3:0] a, output logic [31:0] d);
        logic got;
        got = 1'b0; d = 32'd0;
        @(negedge wb_clk_i);
        s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b0; s_adr_i = a;
        for (int k = 0; k < 4 && !got; k++) begin
            @(negedge wb_clk_i);
            if (s_ack_o) begin got = 1'b1; d = s_dat_o; end
        end
        s_cyc_i = 1'b0; s_stb_i = 1'b0;
        chk("s_ack_rd", 65'(got), 65'd1);
    endtask

    task automatic push_run(input logic [31:0] src, input logic [31:0] dst, input int len);
        logic [31:0] a;
        exp_q.push_back(txn(1'b1, FB + 32'h10, 32'(len)));
        exp_q.push_back(txn(1'b1, FB, 32'd1));
        for (int i = 0; i < len; i++) begin
            a = src + 32'(4 * i);
            exp_q.push_back(txn(1'b0, a, 32'd0));
            exp_q.push_back(txn(1'b1, FB + 32'h80, xval(a)));
            exp_q.push_back(txn(1'b0, FB + 32'h84, 32'd0));
            exp_q.push_back(txn(1'b1, dst + 32'(4 * i), firf(xval(a))));
        end
        for (int p = 0; p < 3; p++) exp_q.push_back(txn(1'b0, FB, 32'd0));
    endtask

    task automatic drain();
        while (obs_q.size() > 0) begin
            if (exp_q.size() == 0) begin
                chk("sb_extra", 65'(obs_q.size()), 65'd0);
                obs_q.delete();
            end else begin
                chk("sb_txn", obs_q.pop_front(), exp_q.pop_front());
            end
        end
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] d;
        logic        ok;
        ok = 1'b0; d = 32'd0;
        for (int k = 0; k < 300 && !ok; k++) begin
            wb_read(4'h0, d);
            drain();
            if (d[2]) ok = 1'b1;
        end
        chk({tag, "_done_seen"}, 65'(ok), 65'd1);
        drain();
        chk({tag, "_ctrl"}, 65'(d), 65'h4);
        chk({tag, "_sb_left"}, 65'(exp_q.size()), 65'd0);
    endtask

    initial begin : main
        logic [31:0] rd;
        logic        seen;
        int          snap;
        int          n;
        wb_rst_i = 1'b1; s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
        s_adr_i = 4'h0; s_dat_i = 32'd0; stall_adr = 32'h0000_0001;
        repeat (3) @(negedge wb_clk_i);
        chk("rst_m_cyc", 65'(m_cyc_o), 65'd0);
        chk("rst_s_ack", 65'(s_ack_o), 65'd0);
        chk("rst_m_adr", 65'(m_adr_o), 65'd0);
        wb_rst_i = 1'b0;
        wb_read(4'h0, rd); chk("ctrl_after_reset", 65'(rd), 65'd0);
        wb_read(4'h4, rd); chk("src_after_reset", 65'(rd), 65'd0);

        // Main three-sample run, with LEN/GO writes attempted while busy.
        wb_write(4'h4, 32'h3800_0000);
        wb_write(4'h8, 32'h3800_0100);
        wb_write(4'hC, 32'd3);
        wb_read(4'h8, rd); chk("dst_readback", 65'(rd), 65'h3800_0100);
        wb_read(4'h6, rd); chk("unmapped_read", 65'(rd), 65'd0);
        push_run(32'h3800_0000, 32'h3800_0100, 3);
        wb_write(4'h0, 32'd1);
        wb_write(4'hC, 32'd5);
        wb_write(4'h0, 32'd1);
        wb_read(4'hC, rd); chk("len_busy", 65'(rd), 65'd3);
        wb_read(4'h0, rd); chk("ctrl_busy", 65'(rd), 65'h2);
        wait_done("run1");
        snap = cyc_cycles;
        repeat (20) @(negedge wb_clk_i);
        drain();
        chk("go_ignored_no_cyc", 65'(cyc_cycles - snap), 65'd0);
        wb_read(4'hC, rd); chk("len_after_run", 65'(rd), 65'd3);

        // Address wrap past 2^32.
        wb_write(4'h4, 32'hFFFF_FFF8);
        wb_write(4'h8, 32'hFFFF_FFFC);
        wb_write(4'hC, 32'd2);
        push_run(32'hFFFF_FFF8, 32'hFFFF_FFFC, 2);
        wb_write(4'h0, 32'd1);
        wait_done("wrap");

        // LEN=0: no master traffic, DONE two cycles after the GO ack.
        wb_write(4'hC, 32'd0);
        snap = cyc_cycles;
        wb_write(4'h0, 32'd1);
        wb_read(4'h0, rd); chk("len0_ctrl", 65'(rd), 65'h4);
        repeat (10) @(negedge wb_clk_i);
        chk("len0_no_cyc", 65'(cyc_cycles - snap), 65'd0);
        drain();

        // Reset in the middle of a WRX transaction.
        wb_write(4'h4, 32'h3800_0000);
        wb_write(4'hC, 32'd2);
        stall_adr = FB + 32'h80;
        wb_write(4'h0, 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge wb_clk_i);
            if (m_cyc_o && m_adr_o == FB + 32'h80) seen = 1'b1;
        end
        chk("wrx_reached", 65'(seen), 65'd1);
        chk("wrx_data", 65'(m_dat_o), 65'(xval(32'h3800_0000)));
        wb_rst_i = 1'b1;
        #1;
        chk("rst_mid_cyc", 65'(m_cyc_o), 65'd0);
        chk("rst_mid_stb", 65'(m_stb_o), 65'd0);
        chk("rst_mid_dat", 65'(m_dat_o), 65'd0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        stall_adr = 32'h0000_0001;
        obs_q.delete();
        exp_q.delete();
        wb_read(4'h0, rd); chk("ctrl_after_midrst", 65'(rd), 65'd0);
        wb_read(4'hC, rd); chk("len_after_midrst", 65'(rd), 65'd0);
        wb_read(4'h4, rd); chk("src_after_midrst", 65'(rd), 65'd0);

`ifdef FIR_SEQ_TIMEOUT_EN
        // Ack never arrives: abort after TIMEOUT_CYC cycles with ERR and DONE.
        stall_adr = FB + 32'h10;
        wb_write(4'hC, 32'd3);
        wb_write(4'h0, 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge wb_clk_i);
            if (m_cyc_o) seen = 1'b1;
        end
        chk("to_cyc_seen", 65'(seen), 65'd1);
        n = 0;
        while (m_cyc_o && n < 600) begin
            n++;
            @(negedge wb_clk_i);
        end
        chk("to_cycles", 65'(n), 65'd255);
        wb_read(4'h0, rd); chk("to_ctrl", 65'(rd), 65'hC);
        stall_adr = 32'h0000_0001;
        obs_q.delete();
`else
        n = 0;
        wb_read(4'h0, rd); chk("err_reads_zero", 65'(rd[3]), 65'(n));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fir_wb_sequencer.md
FIR_WB_SEQUENCER -- requirements
Module: fir_wb_sequencer

Interface
REQ-001 SHALL have parameter FIR_BASE, default 32'h3000_0000: base address of the FIR Wishbone window.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 255: maximum number of cycles a master transaction may wait for ack.
REQ-003 SHALL have port wb_clk_i, input, 1 bit: clock; all logic is rising-edge.
REQ-004 SHALL have port wb_rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port s_cyc_i, input, 1 bit: configuration slave cycle.
REQ-006 SHALL have port s_stb_i, input, 1 bit: configuration slave strobe.
REQ-007 SHALL have port s_we_i, input, 1 bit: configuration slave write enable.
REQ-008 SHALL have port s_adr_i, input, 4 bits: configuration register byte offset.
REQ-009 SHALL have port s_dat_i, input, 32 bits: configuration write data.
REQ-010 SHALL have port s_dat_o, output, 32 bits: configuration read data.
REQ-011 SHALL have port s_ack_o, output, 1 bit: configuration acknowledge.
REQ-012 SHALL have port m_cyc_o, output, 1 bit: master cycle to the FIR window and user memory.
REQ-013 SHALL have port m_stb_o, output, 1 bit: master strobe.
REQ-014 SHALL have port m_we_o, output, 1 bit: master write enable; all master accesses are full-word.
REQ-015 SHALL have port m_adr_o, output, 32 bits: master address.
REQ-016 SHALL have port m_dat_o, output, 32 bits: master write data.
REQ-017 SHALL have port m_dat_i, input, 32 bits: master read data.
REQ-018 SHALL have port m_ack_i, input, 1 bit: master acknowledge.

Function
REQ-019 SHALL ack a slave access with a single-cycle s_ack_o pulse one cycle after s_cyc_i&s_stb_i, with no wait states.
REQ-020 SHALL implement registers: 0x0 CTRL (bit0 GO write-1, bit1 BUSY ro, bit2 DONE ro sticky, bit3 ERR ro sticky); 0x4 SRC; 0x8 DST; 0xC LEN[9:0]; any other offset reads 0.
REQ-021 SHALL ignore writes to SRC/DST/LEN and GO while BUSY=1; a GO accepted while idle SHALL clear DONE and ERR.
REQ-022 SHALL use FSM states IDLE, SETLEN, START, RDX, WRX, RDY, WRY, POLL, FIN.
REQ-023 SHALL, on GO with LEN=0, go IDLE->FIN, set DONE next cycle, and issue no master transaction.
REQ-024 SHALL, on GO with LEN>0, perform SETLEN (write LEN to FIR_BASE+0x10), then START (write 1 to FIR_BASE+0x00).
REQ-025 SHALL, per sample i, perform RDX (read SRC+4i), WRX (write that word to FIR_BASE+0x80), RDY (read FIR_BASE+0x84), WRY (write that word to DST+4i).
REQ-026 SHALL hold m_cyc_o=m_stb_o=1 with stable adr/we/dat for each transaction until m_ack_i, deassert them for at least one cycle after ack, and advance state on the ack cycle.
REQ-027 SHALL go WRY->RDX while i+1<LEN, otherwise WRY->POLL; address arithmetic is 32-bit modulo 2^32 (wrap, no error).
REQ-028 SHALL, in POLL, read FIR_BASE+0x00 repeatedly until bit1 (ap_done)=1, then go to FIN.
REQ-029 SHALL, in FIN, set DONE, clear BUSY and return to IDLE in one cycle; BUSY=1 in every state except IDLE.

Reset
REQ-030 SHALL, on wb_rst_i, immediately force state IDLE, i=0, all registers 0, and s_ack_o, m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o, s_dat_o to 0, including in the middle of a transaction.
REQ-031 SHALL begin operating on the first rising edge after wb_rst_i deasserts.

Configuration
REQ-032 SHALL, with FIR_SEQ_TIMEOUT_EN defined, count cycles waiting for m_ack_i and, on reaching TIMEOUT_CYC, drop cyc/stb, set ERR and DONE, and return to IDLE; a POLL loop SHALL also abort after TIMEOUT_CYC consecutive reads with ap_done=0.
REQ-033 SHALL, without FIR_SEQ_TIMEOUT_EN, wait indefinitely for ack and ap_done, and ERR SHALL read 0.

Verification
REQ-034 SHALL verify: LEN=3, SRC=0x3800_0000, DST=0x3800_0100, GO -> master sequence W 0x3000_0010=3, W 0x3000_0000=1, then 3x(R X, W 0x80, R 0x84, W DST+4i), poll, DONE=1.
REQ-035 SHALL verify: LEN=0, GO -> no m_cyc_o; CTRL reads 0x4 two cycles after the GO ack.
REQ-036 SHALL verify: write LEN=5 while BUSY -> LEN unchanged, and GO ignored.
REQ-037 SHALL verify: assert wb_rst_i during WRX -> m_cyc_o=0 in the same cycle, CTRL=0 after reset.
REQ-038 SHALL verify: with FIR_SEQ_TIMEOUT_EN, m_ack_i held 0 -> abort after 255 cycles, CTRL=0xC.
